// File: rtl/muldiv_pkg.sv
// Shared op codes, state encoding and datapath width for the HI/LO muldiv controller.
package muldiv_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;
endpackage

// File: rtl/div_core.sv
// Unsigned restoring divider: one quotient bit per step, cnt counts W-1 down to 0.
module div_core #(
  parameter int W  = 32,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [W-1:0]  dividend,
  input  logic [W-1:0]  divisor,
  output logic [W-1:0]  quot,
  output logic [W-1:0]  rem,
  output logic [CW-1:0] cnt,
  output logic          done
);
  logic [W-1:0] dvsr;
  logic [W:0]   partial;
  logic [W:0]   diff;

  // The remainder never reaches the divisor, so the shifted value fits in W+1 bits
  // and diff[W] acts as the borrow of the trial subtraction.
  assign partial = {rem, quot[W-1]};
  assign diff    = partial - {1'b0, dvsr};
  assign done    = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      quot <= '0;
      rem  <= '0;
      dvsr <= '0;
      cnt  <= '0;
    end else if (load) begin
      quot <= dividend;
      rem  <= '0;
      dvsr <= divisor;
      cnt  <= CW'(W - 1);
    end else if (step) begin
      if (!diff[W]) begin
        rem  <= diff[W-1:0];
        quot <= {quot[W-2:0], 1'b1};
      end else begin
        rem  <= partial[W-1:0];
        quot <= {quot[W-2:0], 1'b0};
      end
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer for MULTU/DIV/DIVU/MTHI/MTLO with CPU stall; MULDIV_ZERO_FAST_EN
// short-circuits divide-by-zero straight to DONE.
module muldiv_ctrl #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            op_valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            stall,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out,
  output logic            busy
);
  import muldiv_pkg::*;

`ifdef MULDIV_ZERO_FAST_EN
  localparam logic ZERO_FAST = 1'b1;
`else
  localparam logic ZERO_FAST = 1'b0;
`endif
  localparam int CW = $clog2(XLEN);

  state_t            state;
  logic              kind_mul;
  logic              q_neg;
  logic              r_neg;
  logic              div0;
  logic [XLEN-1:0]   rs_lat;
  logic [XLEN-1:0]   mul_a;
  logic [XLEN-1:0]   mul_b;
  logic [2*XLEN-1:0] prod;

  logic            is_mul, is_div, is_sdiv, accept;
  logic            div_load, div_step, div_done;
  logic [XLEN-1:0] dvd_abs, dvs_abs, quot, rem, q_fix, r_fix;
  logic [CW-1:0]   cnt;

  always_comb begin
    is_mul   = (op == OP_MULTU);
    is_sdiv  = (op == OP_DIV);
    is_div   = is_sdiv || (op == OP_DIVU);
    accept   = (state == S_IDLE) && op_valid;
    dvd_abs  = (is_sdiv && rs_data[XLEN-1]) ? -rs_data : rs_data;
    dvs_abs  = (is_sdiv && rt_data[XLEN-1]) ? -rt_data : rt_data;
    div_load = ena && accept && is_div;
    div_step = ena && (state == S_DIV);
    stall    = (accept && (is_mul || is_div)) || (state == S_MUL) || (state == S_DIV);
    q_fix    = q_neg ? -quot : quot;
    r_fix    = r_neg ? -rem : rem;
  end

  div_core #(.W(XLEN), .CW(CW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (dvd_abs),
    .divisor  (dvs_abs),
    .quot     (quot),
    .rem      (rem),
    .cnt      (cnt),
    .done     (div_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      kind_mul <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div0     <= 1'b0;
      rs_lat   <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      prod     <= '0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            if (is_mul) begin
              kind_mul <= 1'b1;
              mul_a    <= rs_data;
              mul_b    <= rt_data;
              state    <= S_MUL;
              busy     <= 1'b1;
            end else if (is_div) begin
              kind_mul <= 1'b0;
              q_neg    <= is_sdiv && (rs_data[XLEN-1] ^ rt_data[XLEN-1]);
              r_neg    <= is_sdiv && rs_data[XLEN-1];
              div0     <= (rt_data == '0);
              rs_lat   <= rs_data;
              if (ZERO_FAST && (rt_data == '0)) begin
                state <= S_DONE;
              end else begin
                state <= S_DIV;
                busy  <= 1'b1;
              end
            end else if (op == OP_MTHI) begin
              hi_out <= rs_data;
            end else if (op == OP_MTLO) begin
              lo_out <= rs_data;
            end
          end
        end
        S_MUL: begin
          prod  <= {{XLEN{1'b0}}, mul_a} * {{XLEN{1'b0}}, mul_b};
          state <= S_DONE;
          busy  <= 1'b0;
        end
        S_DIV: begin
          if (div_done) begin
            state <= S_DONE;
            busy  <= 1'b0;
          end
        end
        S_DONE: begin
          // Divide-by-zero reports the raw dividend, not the sign-corrected remainder.
          if (kind_mul) begin
            hi_out <= prod[2*XLEN-1:XLEN];
            lo_out <= prod[XLEN-1:0];
          end else if (div0) begin
            hi_out <= rs_lat;
            lo_out <= '1;
          end else begin
            hi_out <= r_fix;
            lo_out <= q_fix;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed table, reset/enable sequences, random ops vs model.
module tb_muldiv_ctrl;
  localparam logic [2:0] T_MULTU = 3'd1;
  localparam logic [2:0] T_DIV   = 3'd2;
  localparam logic [2:0] T_DIVU  = 3'd3;
  localparam logic [2:0] T_MTHI  = 3'd4;
  localparam logic [2:0] T_MTLO  = 3'd5;
`ifdef MULDIV_ZERO_FAST_EN
  localparam int ZS = 1;
`else
  localparam int ZS = 33;
`endif

  logic        clk = 1'b0;
  logic        rst, ena, op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data, hi_out, lo_out;
  logic        stall, busy;

  int errors = 0;
  int checks = 0;

  muldiv_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .op_valid (op_valid),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .stall    (stall),
    .hi_out   (hi_out),
    .lo_out   (lo_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          st;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: results from plain arithmetic on the architectural definition.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] h, inout logic [31:0] l, output int st);
    logic [63:0] p;
    st = 0;
    case (o)
      T_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        h = p[63:32];
        l = p[31:0];
        st = 2;
      end
      T_DIV, T_DIVU: begin
        st = 33;
        if (b == 32'h0) begin
          l = 32'hFFFF_FFFF;
          h = a;
          st = ZS;
        end else if (o == T_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000;
          h = 32'h0;
        end else if (o == T_DIV) begin
          l = $signed(a) / $signed(b);
          h = $signed(a) % $signed(b);
        end else begin
          l = a / b;
          h = a % b;
        end
      end
      T_MTHI: h = a;
      T_MTLO: l = a;
      default: st = 0;
    endcase
  endtask

  // Called at a negedge; presents the op and holds it like a stalled CPU until the
  // retire cycle. ena is dropped for cycles [hold_at, hold_at+hold_len) after acceptance.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int exp_stall, input int hold_at, input int hold_len,
                        output int n_stall);
    int i;
    bit busy_bad;
    n_stall = 0;
    busy_bad = 1'b0;
    i = 0;
    op_valid = 1'b1;
    op = o;
    rs_data = a;
    rt_data = b;
    forever begin
      ena = !(i >= hold_at && i < hold_at + hold_len);
      #1;
      if (busy !== ((i >= 1 && i < exp_stall) ? 1'b1 : 1'b0)) busy_bad = 1'b1;
      if (stall !== 1'b1) break;
      n_stall++;
      i++;
      if (i > 200) break;
      @(negedge clk);
    end
    @(negedge clk);
    op_valid = 1'b0;
    ena = 1'b1;
    #1;
    chk("busy_profile", {63'h0, busy_bad}, 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ns, est;
    logic [31:0] mh, ml, a, b;
    logic [2:0]  o;
    int r, ha, hl;

    tbl[0]  = '{T_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 2};
    tbl[1]  = '{T_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    tbl[2]  = '{T_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
    tbl[3]  = '{T_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33};
    tbl[4]  = '{T_DIVU,  32'h1234,      32'h0,         32'h1234,      32'hFFFF_FFFF, ZS};
    tbl[5]  = '{T_DIV,   32'hFFFF_FFEC, 32'h0,         32'hFFFF_FFEC, 32'hFFFF_FFFF, ZS};
    tbl[6]  = '{T_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
    tbl[7]  = '{T_MTHI,  32'hDEAD_BEEF, 32'h5,         32'hDEAD_BEEF, 32'hFFFF_FFFD, 0};
    tbl[8]  = '{T_MTLO,  32'h1234_5678, 32'h6,         32'hDEAD_BEEF, 32'h1234_5678, 0};
    tbl[9]  = '{3'd0,    32'd5,         32'd6,         32'hDEAD_BEEF, 32'h1234_5678, 0};
    tbl[10] = '{3'd7,    32'd9,         32'd0,         32'hDEAD_BEEF, 32'h1234_5678, 0};
    tbl[11] = '{T_MULTU, 32'h0,         32'hFFFF_FFFF, 32'h0,         32'h0,         2};
    tbl[12] = '{T_DIV,   32'h8000_0000, 32'd1,         32'h0,         32'h8000_0000, 33};
    tbl[13] = '{T_DIVU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         33};

    rst = 1'b0;
    ena = 1'b1;
    op_valid = 1'b0;
    op = 3'd0;
    rs_data = 32'h0;
    rt_data = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_stall", {63'h0, stall}, 64'h0);
    chk("reset_busy",  {63'h0, busy},  64'h0);
    chk("reset_hi",    {32'h0, hi_out}, 64'h0);
    chk("reset_lo",    {32'h0, lo_out}, 64'h0);

    for (int k = 0; k < 14; k++) begin
      run_op(tbl[k].op, tbl[k].rs, tbl[k].rt, tbl[k].st, 1000, 0, ns);
      chk($sformatf("vec%0d_stall", k), 64'(ns), 64'(tbl[k].st));
      chk($sformatf("vec%0d_hi", k), {32'h0, hi_out}, {32'h0, tbl[k].hi});
      chk($sformatf("vec%0d_lo", k), {32'h0, lo_out}, {32'h0, tbl[k].lo});
    end

    // MULTU with ena low for 3 cycles while in MUL.
    run_op(T_MULTU, 32'h0001_0000, 32'h0003_0000, 5, 1, 3, ns);
    chk("ena_stall", 64'(ns), 64'd5);
    chk("ena_hi", {32'h0, hi_out}, 64'h3);
    chk("ena_lo", {32'h0, lo_out}, 64'h0);

    // Reset during a divide: abort without HI/LO update, then MTHI and DIVU.
    run_op(T_MTLO, 32'h1111_2222, 32'h0, 0, 1000, 0, ns);
    op_valid = 1'b1;
    op = T_DIV;
    rs_data = 32'd100;
    rt_data = 32'd3;
    repeat (9) @(negedge clk);
    #1;
    chk("abort_pre_stall", {63'h0, stall}, 64'h1);
    rst = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_stall", {63'h0, stall}, 64'h0);
    chk("abort_busy",  {63'h0, busy},  64'h0);
    chk("abort_hi",    {32'h0, hi_out}, 64'h0);
    chk("abort_lo",    {32'h0, lo_out}, 64'h0);
    run_op(T_MTHI, 32'hAAAA_5555, 32'h0, 0, 1000, 0, ns);
    chk("mthi_stall", 64'(ns), 64'd0);
    chk("mthi_hi", {32'h0, hi_out}, 64'hAAAA_5555);
    run_op(T_DIVU, 32'd1000, 32'd7, 33, 1000, 0, ns);
    chk("post_divu_stall", 64'(ns), 64'd33);
    chk("post_divu_hi", {32'h0, hi_out}, 64'd6);
    chk("post_divu_lo", {32'h0, lo_out}, 64'd142);

    // Random ops against the reference model, back to back, with random ena gaps.
    mh = hi_out;
    ml = lo_out;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r < 2) o = T_MULTU;
      else if (r < 5) o = T_DIV;
      else if (r < 7) o = T_DIVU;
      else if (r == 7) o = T_MTHI;
      else if (r == 8) o = T_MTLO;
      else o = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd6;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'h0;
      else if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 16);
      if ($urandom_range(0, 9) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      model(o, a, b, mh, ml, est);
      ha = 1000;
      hl = 0;
      if (est > 1) begin
        ha = $urandom_range(1, est - 1);
        hl = $urandom_range(0, 2);
      end
      run_op(o, a, b, est + hl, ha, hl, ns);
      chk($sformatf("rnd%0d_stall op=%0d", k, o), 64'(ns), 64'(est + hl));
      chk($sformatf("rnd%0d_hi a=%h b=%h", k, a, b), {32'h0, hi_out}, {32'h0, mh});
      chk($sformatf("rnd%0d_lo a=%h b=%h", k, a, b), {32'h0, lo_out}, {32'h0, ml});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
